// File: rtl/instr_encode_loader_if.sv
// Bus between an instruction-field producer and the encode/loader block,
// carrying the request handshake and the instruction-memory write port.
interface instr_encode_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        kind;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [12:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              err;
  logic              full;
  logic [ADDR_W:0]   count;

  // Producer side: drives request fields, observes the loader.
  modport master (
    output clear, in_valid, kind, rd, rs1, rs2, funct3, funct7b5, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, err, full, count
  );

  // Loader side.
  modport slave (
    input  clear, in_valid, kind, rd, rs1, rs2, funct3, funct7b5, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, err, full, count
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes LW/SW/R_TYPE/BEQ requests into RV32I words and writes them
// sequentially into an instruction memory image, one word per two cycles.
module instr_encode_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_encode_loader_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] KIND_LW  = 2'b00;
  localparam logic [1:0] KIND_SW  = 2'b01;
  localparam logic [1:0] KIND_R   = 2'b10;
  localparam logic [1:0] KIND_BEQ = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    FULL  = 2'b10
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptrNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNext;
  logic [31:0]       wdata;
  logic [31:0]       wdataNext;
  logic              errQ;
  logic              errNext;
  logic [31:0]       encWord;
  logic              illegal;

  // Instruction encoding and legality of the presented request.
  always_comb begin
    encWord = 32'h0000_0000;
    illegal = 1'b0;
    case (bus.kind)
      KIND_LW: begin
        encWord = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
        illegal = (bus.imm[12] != bus.imm[11]);
      end
      KIND_SW: begin
        encWord = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
        illegal = (bus.imm[12] != bus.imm[11]);
      end
      KIND_R: begin
        encWord = {(bus.funct7b5 ? 7'b0100000 : 7'b0000000), bus.rs2, bus.rs1,
                   bus.funct3, bus.rd, 7'b0110011};
      end
      KIND_BEQ: begin
        encWord = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                   bus.imm[4:1], bus.imm[11], 7'b1100011};
        illegal = bus.imm[0];
      end
      default: begin
        encWord = 32'h0000_0000;
        illegal = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update; clear overrides everything.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    cntNext   = cnt;
    wdataNext = wdata;
    errNext   = 1'b0;
    if (bus.clear) begin
      stateNext = IDLE;
      ptrNext   = '0;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (illegal) begin
              errNext = 1'b1;
            end else begin
              wdataNext = encWord;
              stateNext = WRITE;
            end
          end
        end
        WRITE: begin
          ptrNext   = ptr + ADDR_W'(1);
          cntNext   = cnt + CNT_W'(1);
          // Pointer all-ones means the last slot was just written.
          stateNext = (&ptr) ? FULL : IDLE;
        end
        FULL: begin
          stateNext = FULL;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      wdata <= 32'h0000_0000;
      errQ  <= 1'b0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      cnt   <= cntNext;
      wdata <= wdataNext;
      errQ  <= errNext;
    end
  end

  // Outputs decode directly from registered state so rst acts without an edge.
  assign bus.in_ready  = (state == IDLE) && !bus.clear;
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = ptr;
  assign bus.mem_wdata = wdata;
  assign bus.err       = errQ;
  assign bus.full      = (state == FULL);
  assign bus.count     = cnt;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader with a 4-word image.
module tb_instr_encode_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_encode_loader_if #(.ADDR_W(AW)) bus();

  instr_encode_loader #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [12:0] imm;
    logic        illegal;
    logic [31:0] word;
  } vecT;

  vecT tbl[10];
  int  total = 0;
  int  bad = 0;
  int  expCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    bus.kind     = tbl[i].kind;
    bus.rd       = tbl[i].rd;
    bus.rs1      = tbl[i].rs1;
    bus.rs2      = tbl[i].rs2;
    bus.funct3   = tbl[i].f3;
    bus.funct7b5 = tbl[i].f7;
    bus.imm      = tbl[i].imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    bus.clear = 1'b1;
    #1;
    chk("clr_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 bus.clear = 1'b0;
    expCnt = 0;
    @(negedge clk);
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_full", 32'(bus.full), 32'd0);
    chk("clr_addr", 32'(bus.mem_addr), 32'd0);
    chk("clr_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // One request: accept, then check the N+1 cycle and the N+2 cycle.
  task automatic runVec(input int i);
    if (expCnt == DEPTH) pulseClear();
    @(negedge clk);
    chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'd1);
    drive(i);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    if (tbl[i].illegal) begin
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'd1);
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'd0);
    end else begin
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'd1);
      chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(expCnt % DEPTH));
      chk($sformatf("v%0d_word", i), bus.mem_wdata, tbl[i].word);
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'd0);
    end
    @(negedge clk);
    if (!tbl[i].illegal) expCnt++;
    chk($sformatf("v%0d_we_after", i), 32'(bus.mem_we), 32'd0);
    chk($sformatf("v%0d_err_after", i), 32'(bus.err), 32'd0);
    chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(expCnt));
    chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(expCnt == DEPTH));
    chk($sformatf("v%0d_ptr", i), 32'(bus.mem_addr), 32'(expCnt % DEPTH));
    chk($sformatf("v%0d_ready_after", i), 32'(bus.in_ready), 32'(expCnt != DEPTH));
  endtask

  initial begin
    //        kind   rd     rs1    rs2    f3    f7    imm       illegal word
    tbl[0] = '{2'b00, 5'd5,  5'd2,  5'd0,  3'd0, 1'b0, 13'h0008, 1'b0, 32'h00812283};
    tbl[1] = '{2'b01, 5'd0,  5'd2,  5'd6,  3'd0, 1'b0, 13'h000C, 1'b0, 32'h00612623};
    tbl[2] = '{2'b10, 5'd7,  5'd5,  5'd6,  3'd0, 1'b0, 13'h0000, 1'b0, 32'h006283B3};
    tbl[3] = '{2'b10, 5'd7,  5'd5,  5'd6,  3'd0, 1'b1, 13'h0000, 1'b0, 32'h406283B3};
    tbl[4] = '{2'b11, 5'd0,  5'd5,  5'd6,  3'd0, 1'b0, 13'h1FFC, 1'b0, 32'hFE628EE3};
    tbl[5] = '{2'b11, 5'd0,  5'd5,  5'd6,  3'd0, 1'b0, 13'h0003, 1'b1, 32'h00000000};
    tbl[6] = '{2'b00, 5'd5,  5'd2,  5'd0,  3'd0, 1'b0, 13'h0800, 1'b1, 32'h00000000};
    tbl[7] = '{2'b00, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 13'h1FFF, 1'b0, 32'hFFF02083};
    tbl[8] = '{2'b01, 5'd0,  5'd4,  5'd3,  3'd0, 1'b0, 13'h1800, 1'b0, 32'h80322023};
    tbl[9] = '{2'b10, 5'd31, 5'd31, 5'd31, 3'd7, 1'b0, 13'h0000, 1'b0, 32'h01FFFFB3};

    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.kind = 2'b00;
    bus.rd = 5'd0;
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.imm = 13'h0000;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // Encodings, illegal requests, fill to full and clear.
    for (int i = 0; i < 10; i++) runVec(i);

    // Full: in_valid held for several cycles must be ignored.
    @(negedge clk);
    drive(0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_ready", 32'(bus.in_ready), 32'd0);
      chk("full_we", 32'(bus.mem_we), 32'd0);
      chk("full_count", 32'(bus.count), 32'(DEPTH));
      chk("full_flag", 32'(bus.full), 32'd1);
    end
    bus.in_valid = 1'b0;
    pulseClear();

    // Clear asserted during WRITE aborts the write.
    runVec(0);
    @(negedge clk);
    drive(1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    expCnt = 0;
    @(negedge clk);
    chk("clrw_we", 32'(bus.mem_we), 32'd0);
    chk("clrw_count", 32'(bus.count), 32'd0);
    chk("clrw_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    chk("clrw_we2", 32'(bus.mem_we), 32'd0);
    chk("clrw_ready", 32'(bus.in_ready), 32'd1);

    // Clear together with in_valid in IDLE: no transfer.
    runVec(0);
    @(negedge clk);
    drive(2);
    bus.clear = 1'b1;
    #1;
    chk("coll_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    expCnt = 0;
    @(negedge clk);
    chk("coll_we", 32'(bus.mem_we), 32'd0);
    chk("coll_err", 32'(bus.err), 32'd0);
    chk("coll_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    chk("coll_we2", 32'(bus.mem_we), 32'd0);

    // Async reset in the middle of a WRITE cycle.
    runVec(0);
    @(negedge clk);
    drive(2);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1;
    chk("arst_we_before", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.mem_we), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_wdata", bus.mem_wdata, 32'h0);
    chk("arst_err", 32'(bus.err), 32'd0);
    chk("arst_full", 32'(bus.full), 32'd0);
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    #1 rst = 1'b0;
    expCnt = 0;
    #1;
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("arst_we_after", 32'(bus.mem_we), 32'd0);
    chk("arst_count_after", 32'(bus.count), 32'd0);
    runVec(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
